ssd_scan_scheduler: RTL and testbench
=====================================

// Module: ssd_scan_scheduler
// PURPOSE
//  Time-slice scheduler for the shared 8-digit seven-segment cathode bus. Gives each digit one
//  DRIVE slot per frame, separated by all-off BLANK gaps that suppress ghosting between digits.
//  Display values enter through a shadow register. A req/ack handshake commits new values only
//  at frame boundaries, so a frame never mixes old and new values.
//  Sits between doodle_top's score/position logic and the An0..An7 / Ca..Dp pins.
// PARAMETERS
//  NUM_DIGITS    8       digits scanned per frame; digit 0 = leftmost = An0
//  DWELL_CYCLES  131072  clk cycles a digit anode is driven per slot (>=1)
//  BLANK_CYCLES  1024    clk cycles all anodes are off before each DRIVE slot (>=1)
// PORTS
//  clk         in   1   system clock (ClkPort domain)
//  rst         in   1   asynchronous reset, active-high
//  digits_in   in   32  nibble i = digits_in[4i+3:4i] = hex value for digit i
//  blank_in    in   8   bit i = 1: digit i dark for its slot
//  dp_in       in   8   bit i = 1: decimal point of digit i lit
//  load_req    in   1   level request to commit digits_in/blank_in/dp_in
//  load_ack    out  1   one-cycle pulse: inputs captured into shadow
//  an          out  8   anodes, active-low, an[i] -> An<i>
//  cath        out  8   {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
//  frame_start out  1   one-cycle pulse on entry to BLANK of digit 0
//  cur_digit   out  3   index of digit owning the current/next slot
// BEHAVIOUR
//  - Async reset, applied immediately even mid-slot:
//    an=8'hFF, cath=8'hFF, load_ack=0, frame_start=0, cur_digit=0, state=BLANK, count=0.
//    Shadow reset: digits=0, blank=8'hFF (display dark until first load), dp=0.
//  - FSM, two states:
//    BLANK: an=8'hFF for BLANK_CYCLES. On the last BLANK cycle, go to DRIVE.
//    DRIVE: an[cur_digit]=0 unless shadow blank[cur_digit]=1; all other bits stay 1.
//      Lasts DWELL_CYCLES. On the last cycle, go to BLANK with cur_digit+1.
//      Wraps NUM_DIGITS-1 -> 0.
//  - Slot period = BLANK_CYCLES+DWELL_CYCLES. Frame = NUM_DIGITS*slot.
//    Slot timing does not depend on blank bits.
//  - One count register, width $clog2(max(DWELL,BLANK)). Reloaded at each state change.
//  - cath is registered. It is loaded on the first BLANK cycle from shadow nibble/dp of cur_digit.
//    It is held stable through the following DRIVE, so it is never changed while an anode is low.
//    Decode gives {Ca..Cg}, 0 = segment on:
//      0:0000001  1:1001111  2:0010010  3:0000110  4:1001100  5:0100100  6:0100000  7:0001111
//      8:0000000  9:0000100  A:0001000  b:1100000  C:0110001  d:1000010  E:0110000  F:0111000
//    Dp = ~dp[cur_digit]. A blanked digit still gets cath loaded; only its anode is suppressed.
//  - Frame boundary = the last DRIVE cycle of digit NUM_DIGITS-1.
//    If load_req=1 on that cycle, the shadow captures digits_in/blank_in/dp_in.
//    load_ack=1 on the next cycle, which is the first BLANK cycle of digit 0.
//    frame_start=1 on that same cycle.
//  - load_req asserted mid-frame: nothing is captured until the next boundary.
//    The remaining digits show old shadow values.
//  - Requester holds inputs stable while load_req=1 and drops load_req after load_ack.
//    If load_req is still 1 at the next boundary, a second capture and ack occur (level semantics).
//  - New values first appear on cath in digit 0's BLANK, one cycle after capture, with no partial frames.
//  - Boundary cycle with load_req=0: no capture, load_ack stays 0, frame_start still pulses.
// TESTING (NUM_DIGITS=8, DWELL_CYCLES=4, BLANK_CYCLES=2; slot=6, frame=48 cycles)
//  1 Reset, no load, run 100 cycles -> an=8'hFF throughout.
//    frame_start pulses at frame starts, 48 cycles apart. load_ack=0.
//  2 load_req=1 with digits_in=32'hFEDC_BA98, blank_in=0, dp_in=8'h01, held until ack
//    -> load_ack 1 cycle at the frame start.
//    Digit 0: an=8'hFE for 4 cycles after 2 blank cycles, cath=8'b0000_0000 (8, Dp lit).
//    Digit 1: an=8'hFD, cath=8'b0000_1001 (9).
//  3 After 2, assert load_req in digit 3's slot with digits_in=0
//    -> digits 3..7 keep showing the old values, ack only at the boundary.
//    Next frame: digit 0 cath=8'b0000_0011.
//  4 blank_in=8'h0A loaded -> an never drives bits 1 and 3.
//    Those slots keep full 6-cycle length with an=8'hFF.
//  5 Assert rst mid-DRIVE of digit 5 -> same cycle an=8'hFF, cath=8'hFF, dark until the next load.
//  6 Hold load_req=1 for 2 frames -> two load_ack pulses, 48 cycles apart.

Source files
------------

// File: rtl/ssd_scan_scheduler.sv
// Time-slice scanner for a shared seven-segment cathode bus: each digit gets a blank gap then a
// drive slot per frame; display values are committed from a shadow register only at frame ends.
module ssd_scan_scheduler #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DWELL_CYCLES = 131072,
  parameter int unsigned BLANK_CYCLES = 1024,
  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_req,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              cath,
  output logic                    frame_start,
  output logic [DigW-1:0]         cur_digit
);

  localparam int unsigned MaxCyc = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [DigW-1:0] LastDigit = DigW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [DigW-1:0]         digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   blank_q, dp_q;
  logic [7:0]              cath_q, cath_d;
  logic                    ack_q, fs_q;
  logic                    boundary, cath_load;
  logic [3:0]              nibble;
  logic [6:0]              seg;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q + 1'b1;
    digit_d   = digit_q;
    boundary  = 1'b0;
    cath_load = 1'b0;
    unique case (state_q)
      StBlank: begin
        cath_load = (count_q == '0);
        if (count_q == BlankLast) begin
          state_d = StDrive;
          count_d = '0;
        end
      end
      StDrive: begin
        if (count_q == DwellLast) begin
          state_d  = StBlank;
          count_d  = '0;
          boundary = (digit_q == LastDigit);
          digit_d  = (digit_q == LastDigit) ? '0 : digit_q + 1'b1;
        end
      end
      default: begin
        state_d = StBlank;
        count_d = '0;
      end
    endcase
  end

  // Segment pattern {a..g}, low = lit.
  always_comb begin
    nibble = digits_q[4*digit_q +: 4];
    seg    = 7'b1111111;
    unique case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    cath_d = {seg, ~dp_q[digit_q]};
  end

  // A blanked digit keeps its slot timing; only its anode stays off.
  always_comb begin
    an = '1;
    if (state_q == StDrive && !blank_q[digit_q]) an[digit_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StBlank;
      count_q  <= '0;
      digit_q  <= '0;
      cath_q   <= '1;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
      digits_q <= '0;
      blank_q  <= '1;
      dp_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      digit_q <= digit_d;
      ack_q   <= boundary & load_req;
      fs_q    <= boundary;
      if (cath_load) cath_q <= cath_d;
      if (boundary && load_req) begin
        digits_q <= digits_in;
        blank_q  <= blank_in;
        dp_q     <= dp_in;
      end
    end
  end

  assign load_ack    = ack_q;
  assign frame_start = fs_q;
  assign cath        = cath_q;
  assign cur_digit   = digit_q;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Bench for ssd_scan_scheduler: expected outputs come from a time-based model of the scan
// (slot/frame arithmetic on the cycle index) plus a shadow copy of the committed display values.
module tb_ssd_scan_scheduler;

  localparam int ND    = 8;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits_in = '0;
  logic [7:0]  blank_in = '0;
  logic [7:0]  dp_in = '0;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic [7:0]  an;
  logic [7:0]  cath;
  logic        frame_start;
  logic [2:0]  cur_digit;

  always #5 clk = ~clk;

  ssd_scan_scheduler #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .an         (an),
    .cath       (cath),
    .frame_start(frame_start),
    .cur_digit  (cur_digit)
  );

  int checks = 0;
  int failures = 0;

  // Model state: k = cycles since reset release; m_* = committed shadow and expected cath.
  int          k;
  logic [31:0] m_dig;
  logic [7:0]  m_blank, m_dp, m_cath;
  logic        m_ack;
  int          ack_k[$];

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    m_dig   = '0;
    m_blank = 8'hFF;
    m_dp    = '0;
    m_cath  = 8'hFF;
    m_ack   = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return just after the rise.
  task automatic cycle();
    int         ph, dig;
    logic [7:0] e_an;
    logic       e_fs;
    @(negedge clk);
    ph   = k % SLOT;
    dig  = (k / SLOT) % ND;
    e_an = 8'hFF;
    if (ph >= BL && !m_blank[dig]) e_an[dig] = 1'b0;
    e_fs = (k > 0) && (k % FRAME == 0);
    check("an", an, e_an);
    check("cath", cath, m_cath);
    check("load_ack", {7'd0, load_ack}, {7'd0, m_ack});
    check("frame_start", {7'd0, frame_start}, {7'd0, e_fs});
    check("cur_digit", {5'd0, cur_digit}, 8'(dig));
    if (load_ack === 1'b1) ack_k.push_back(k);
    if (ph == 0) m_cath = {seg7(m_dig[4*dig +: 4]), ~m_dp[dig]};
    m_ack = 1'b0;
    if (k % FRAME == FRAME - 1) begin
      m_ack = load_req;
      if (load_req) begin
        m_dig   = digits_in;
        m_blank = blank_in;
        m_dp    = dp_in;
      end
    end
    k++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME; i++) begin
      if (k % FRAME == pos) break;
      cycle();
    end
  endtask

  // Request a load and hold it through the ack cycle, then drop it.
  task automatic load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
    logic at_boundary;
    digits_in = d;
    blank_in  = b;
    dp_in     = p;
    load_req  = 1'b1;
    for (int i = 0; i < FRAME + 1; i++) begin
      at_boundary = (k % FRAME == FRAME - 1);
      cycle();
      if (at_boundary) break;
    end
    cycle();
    load_req = 1'b0;
  endtask

  initial begin
    int gap;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Dark after reset, frame_start every frame, no ack.
    run(100);

    // First load; digit 0 shows 8 with dp, digit 1 shows 9.
    load(32'hFEDC_BA98, 8'h00, 8'h01);
    run_to(3);
    check("d0_an", an, 8'hFE);
    check("d0_cath", cath, 8'h00);
    run_to(9);
    check("d1_an", an, 8'hFD);
    check("d1_cath", cath, 8'b0000_1001);

    // Mid-frame request: remaining digits keep old values until the boundary.
    run_to(18);
    load(32'h0000_0000, 8'h00, 8'h00);
    run_to(3);
    check("zero_cath", cath, 8'b0000_0011);

    // Blanked digits 1 and 3 keep their slots but never drive.
    load($urandom, 8'h0A, 8'(($urandom_range(0, 255))));
    run_to(9);
    check("blank1_an", an, 8'hFF);
    run_to(21);
    check("blank3_an", an, 8'hFF);
    run(FRAME);

    // Random loads at random points in the frame.
    for (int r = 0; r < 4; r++) begin
      run($urandom_range(0, FRAME - 1));
      load($urandom, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      run($urandom_range(0, FRAME));
    end

    // Level request held across two boundaries: two acks one frame apart.
    run_to(1);
    ack_k.delete();
    digits_in = $urandom;
    blank_in  = 8'($urandom_range(0, 255));
    dp_in     = 8'($urandom_range(0, 255));
    load_req  = 1'b1;
    run(2 * FRAME);
    load_req = 1'b0;
    check("ack_count", 8'(ack_k.size()), 8'd2);
    gap = (ack_k.size() >= 2) ? ack_k[1] - ack_k[0] : -1;
    check("ack_gap", 8'(gap), 8'(FRAME));
    run(10);

    // Asynchronous reset in digit 5's drive window.
    load(32'h1234_5678, 8'h00, 8'hFF);
    run_to(33);
    check("pre_rst_an", an, 8'hDF);
    rst = 1'b1;
    #1;
    check("rst_an", an, 8'hFF);
    check("rst_cath", cath, 8'hFF);
    check("rst_cur", {5'd0, cur_digit}, 8'd0);
    check("rst_ack", {7'd0, load_ack}, 8'd0);
    #1;
    rst = 1'b0;
    model_reset();
    run(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
